// File: rtl/data_fetch_pkg.sv
// data_fetch_pkg: FSM state encoding and latched command record for data_fetch_engine.
// Command field widths match the engine's default parameters.
package data_fetch_pkg;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_LEN_W  = 4;
    localparam int CMD_PE_W   = 4;
    typedef enum logic [1:0] {IDLE, LD_ISSUE, LD_DRAIN, ST_WRITE} state_t;
    typedef struct packed {
        logic                  store;
        logic [CMD_ADDR_W-1:0] base;
        logic [CMD_LEN_W-1:0]  len;
        logic [CMD_PE_W-1:0]   mask;
    } cmd_t;
endpackage

// File: rtl/pe_mask_next.sv
// pe_mask_next: lowest-set-bit encoder picking the next PE lane to service.
module pe_mask_next #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] mask,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) idx = mask[i] ? W'(i) : idx;
    end
    assign found = |mask;
endmodule

// File: rtl/data_fetch_engine.sv
// data_fetch_engine: BRAM port B <-> PE-array burst mover (broadcast loads, multi-lane stores).
module data_fetch_engine
    import data_fetch_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = CMD_ADDR_W,
    parameter int NUM_PE   = CMD_PE_W,
    parameter int LEN_W    = CMD_LEN_W,
    parameter int BRAM_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic                     CMD_STORE,
    input  logic [ADDR_W-1:0]        CMD_BASE,
    input  logic [LEN_W-1:0]         CMD_LEN,
    input  logic [NUM_PE-1:0]        CMD_PE_MASK,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [ADDR_W-1:0]        addrb,
    output logic [DATA_W-1:0]        dinb,
    input  logic [DATA_W-1:0]        doutb,
    output logic                     enb,
    output logic [DATA_W/8-1:0]      web,
    output logic [NUM_PE*DATA_W-1:0] PE_DIN,
    output logic [NUM_PE-1:0]        PE_DIN_VALID,
    input  logic [NUM_PE*DATA_W-1:0] PE_DOUT,
    output logic [NUM_PE-1:0]        PE_DOUT_POP
);
    localparam int LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int WC_W   = LEN_W + $clog2(NUM_PE) + 1;

    state_t              state, state_nx;
    cmd_t                cmd;
    logic [WC_W-1:0]     wc;
    logic [LEN_W-1:0]    bcnt;
    logic [NUM_PE-1:0]   rem, rem_nx, enc_in;
    logic [BRAM_LAT-1:0] vld, vld_behind;
    logic [LANE_W-1:0]   lane;
    logic                found, accept, beat_last, acc, st, done;

    // In IDLE the encoder inspects the offered mask so an empty command is caught at accept.
    assign enc_in     = (state == IDLE) ? CMD_PE_MASK : rem;
    assign accept     = CMD_VALID && (state == IDLE);
    assign beat_last  = bcnt == LEN_W'(cmd.len);
    assign rem_nx     = rem & (rem - 1'b1);
    assign vld_behind = vld << 1;
    assign acc        = (state == LD_ISSUE) || (state == ST_WRITE);
    assign st         = acc && cmd.store;

    pe_mask_next #(.N(NUM_PE), .W(LANE_W)) u_next (
        .mask (enc_in),
        .idx  (lane),
        .found(found)
    );

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = (accept && found) ? (CMD_STORE ? ST_WRITE : LD_ISSUE) : IDLE;
            LD_ISSUE: state_nx = beat_last ? LD_DRAIN : LD_ISSUE;
            LD_DRAIN: state_nx = (vld_behind == '0) ? IDLE : LD_DRAIN;
            ST_WRITE: state_nx = (beat_last && rem_nx == '0) ? IDLE : ST_WRITE;
            default:  state_nx = IDLE;
        endcase
    end

    // vld[0] is the newest read tag; vld[BRAM_LAT-1] marks the beat on doutb this cycle.
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            cmd  <= '0;
            wc   <= '0;
            bcnt <= '0;
            rem  <= '0;
            vld  <= '0;
            done <= 1'b0;
        end else begin
            done <= (state != IDLE && state_nx == IDLE) || (accept && !found);
            vld  <= (vld << 1) | BRAM_LAT'(state == LD_ISSUE);
            if (accept) begin
                cmd  <= '{store: CMD_STORE, base: CMD_ADDR_W'(CMD_BASE),
                          len: CMD_LEN_W'(CMD_LEN), mask: CMD_PE_W'(CMD_PE_MASK)};
                wc   <= '0;
                bcnt <= '0;
                rem  <= CMD_PE_MASK;
            end else if (acc) begin
                wc   <= wc + 1'b1;
                bcnt <= beat_last ? '0 : bcnt + 1'b1;
                if (beat_last) rem <= rem_nx;
            end
        end

    always_comb begin
        CMD_READY    = state == IDLE;
        BUSY         = state != IDLE;
        DONE         = done;
        enb          = acc;
        web          = st ? '1 : '0;
        addrb        = acc ? ADDR_W'(cmd.base) + ADDR_W'(wc) : '0;
        dinb         = st ? PE_DOUT[lane*DATA_W +: DATA_W] : '0;
        PE_DOUT_POP  = st ? NUM_PE'(1) << lane : '0;
        PE_DIN_VALID = vld[BRAM_LAT-1] ? NUM_PE'(cmd.mask) : '0;
        PE_DIN       = {NUM_PE{doutb}};
    end
endmodule

// File: tb/tb_data_fetch_engine.sv
// tb_data_fetch_engine: directed table, reset sequences and random commands against a
// per-cycle reference derived from the command rules (BRAM and PE FIFOs modelled here).
module tb_data_fetch_engine;
    localparam int LAT = 1;

    logic         CLK = 1'b0, RST = 1'b0;
    logic         CMD_VALID, CMD_READY, CMD_STORE, BUSY, DONE, enb;
    logic [31:0]  CMD_BASE, addrb, dinb;
    logic [31:0]  doutb = '0;
    logic [3:0]   CMD_LEN, CMD_PE_MASK, web, PE_DIN_VALID, PE_DOUT_POP;
    logic [127:0] PE_DIN, PE_DOUT;
    logic [31:0]  mem [256];
    int           pops [4] = '{default: 0};
    int           n_chk = 0, n_fail = 0;

    typedef struct {
        string       name;
        logic        st;
        logic [31:0] base;
        logic [3:0]  len;
        logic [3:0]  mask;
        bit          poke;
        int          exp_done;
        int          exp_acc;
    } vec_t;
    vec_t vecs [11];

    data_fetch_engine #(.DATA_W(32), .ADDR_W(32), .NUM_PE(4), .LEN_W(4), .BRAM_LAT(LAT)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_STORE(CMD_STORE),
        .CMD_BASE(CMD_BASE), .CMD_LEN(CMD_LEN), .CMD_PE_MASK(CMD_PE_MASK), .BUSY(BUSY), .DONE(DONE),
        .addrb(addrb), .dinb(dinb), .doutb(doutb), .enb(enb), .web(web), .PE_DIN(PE_DIN),
        .PE_DIN_VALID(PE_DIN_VALID), .PE_DOUT(PE_DOUT), .PE_DOUT_POP(PE_DOUT_POP)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pe_word(input int p, input int n);
        return 32'hB000_0000 | (32'(p) << 20) | (32'(n) & 32'h000F_FFFF);
    endfunction

    always @(posedge CLK) begin
        if (enb && web != 4'h0) mem[addrb[7:0]] <= dinb;
        if (enb && web == 4'h0) doutb <= mem[addrb[7:0]];
        for (int p = 0; p < 4; p++) if (PE_DOUT_POP[p]) pops[p] <= pops[p] + 1;
    end

    always_comb begin
        PE_DOUT = '0;
        for (int p = 0; p < 4; p++) PE_DOUT[p*32 +: 32] = pe_word(p, pops[p]);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic st, input logic [31:0] base, input logic [3:0] len,
                           input logic [3:0] mask, input bit poke, input int d, input int exp_acc);
        int          lanes [$];
        int          cnt0 [4];
        int          nacc, w, b, lane, j, per;
        logic        e_enb, e_vld;
        logic [3:0]  e_web, e_pop;
        logic [31:0] e_addr, e_din, a;
        logic [127:0] e_pedin;
        per = int'(len) + 1;
        for (int p = 0; p < 4; p++) begin
            if (mask[p]) lanes.push_back(p);
            cnt0[p] = pops[p];
        end
        @(negedge CLK);
        chk({tag, " ready_before"}, CMD_READY, 1'b1);
        CMD_VALID = 1'b1; CMD_STORE = st; CMD_BASE = base; CMD_LEN = len; CMD_PE_MASK = mask;
        @(posedge CLK);
        #1;
        CMD_VALID = 1'b0; CMD_STORE = ~st; CMD_BASE = $urandom; CMD_LEN = ~len; CMD_PE_MASK = ~mask;
        nacc = 0;
        for (int k = 1; k <= d + 1; k++) begin
            @(negedge CLK);
            e_enb = 1'b0; e_vld = 1'b0; e_web = '0; e_pop = '0; e_addr = '0; e_din = '0; e_pedin = '0;
            if (!st) begin
                e_enb  = mask != 0 && k <= per;
                e_addr = base + 32'(k - 1);
                b      = k - 1 - LAT;
                if (mask != 0 && b >= 0 && b < per) begin
                    a       = base + 32'(b);
                    e_vld   = 1'b1;
                    e_pedin = {4{mem[a[7:0]]}};
                end
            end else begin
                w = k - 1;
                if (w < lanes.size() * per) begin
                    lane   = lanes[w / per];
                    j      = w % per;
                    e_enb  = 1'b1;
                    e_web  = 4'hF;
                    e_addr = base + 32'(w);
                    e_din  = pe_word(lane, cnt0[lane] + j);
                    e_pop  = 4'(1 << lane);
                end
            end
            chk($sformatf("%s k%0d enb", tag, k), enb, e_enb);
            chk($sformatf("%s k%0d web", tag, k), web, e_web);
            chk($sformatf("%s k%0d pop", tag, k), PE_DOUT_POP, e_pop);
            chk($sformatf("%s k%0d din_valid", tag, k), PE_DIN_VALID, e_vld ? mask : 4'h0);
            chk($sformatf("%s k%0d done", tag, k), DONE, k == d);
            chk($sformatf("%s k%0d ready", tag, k), CMD_READY, k >= d);
            chk($sformatf("%s k%0d busy", tag, k), BUSY, k < d);
            if (e_enb) chk($sformatf("%s k%0d addrb", tag, k), addrb, e_addr);
            if (st || !e_enb) chk($sformatf("%s k%0d dinb", tag, k), dinb, e_din);
            if (e_vld) chk($sformatf("%s k%0d pe_din", tag, k), PE_DIN, e_pedin);
            nacc += int'(enb);
            if (poke && k == 1) begin
                CMD_VALID = 1'b1; CMD_STORE = $urandom_range(0, 1); CMD_BASE = $urandom;
                CMD_LEN = 4'($urandom); CMD_PE_MASK = 4'hF;
            end
            if (poke && k == d - 1) CMD_VALID = 1'b0;
        end
        chk({tag, " access_count"}, 128'(nacc), 128'(exp_acc));
    endtask

    initial begin
        int          nv, nbad, d, acc, n;
        logic        st;
        logic [31:0] base;
        logic [3:0]  len, mask;
        bit          poke;
        CMD_VALID = 1'b0; CMD_STORE = 1'b0; CMD_BASE = '0; CMD_LEN = '0; CMD_PE_MASK = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA0 + 32'(i);
        #1 RST = 1'b1;
        #1;
        chk("reset ready", CMD_READY, 1'b1);
        chk("reset busy", BUSY, 1'b0);
        chk("reset done", DONE, 1'b0);
        chk("reset enb", enb, 1'b0);
        chk("reset web", web, 4'h0);
        chk("reset addrb", addrb, 32'h0);
        chk("reset dinb", dinb, 32'h0);
        chk("reset din_valid", PE_DIN_VALID, 4'h0);
        chk("reset pop", PE_DOUT_POP, 4'h0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        vecs[0]  = '{"bcast_load",   1'b0, 32'h10,        4'd3,  4'hF, 1'b0, 6,  4};
        vecs[1]  = '{"partial_load", 1'b0, 32'h40,        4'd0,  4'h5, 1'b0, 3,  1};
        vecs[2]  = '{"store_1010",   1'b1, 32'h20,        4'd1,  4'hA, 1'b0, 5,  4};
        vecs[3]  = '{"load_mask0",   1'b0, 32'h70,        4'd5,  4'h0, 1'b0, 1,  0};
        vecs[4]  = '{"store_mask0",  1'b1, 32'h74,        4'd2,  4'h0, 1'b0, 1,  0};
        vecs[5]  = '{"wrap_load",    1'b0, 32'hFFFF_FFFE, 4'd3,  4'h3, 1'b0, 6,  4};
        vecs[6]  = '{"store_all",    1'b1, 32'h80,        4'd2,  4'hF, 1'b0, 13, 12};
        vecs[7]  = '{"load_maxlen",  1'b0, 32'h50,        4'd15, 4'h8, 1'b0, 18, 16};
        vecs[8]  = '{"store_maxlen", 1'b1, 32'hC0,        4'd15, 4'h1, 1'b0, 17, 16};
        vecs[9]  = '{"busy_poke_ld", 1'b0, 32'h60,        4'd2,  4'h6, 1'b1, 5,  3};
        vecs[10] = '{"busy_poke_st", 1'b1, 32'h90,        4'd0,  4'h9, 1'b1, 3,  2};
        for (int i = 0; i < 11; i++)
            run_cmd(vecs[i].name, vecs[i].st, vecs[i].base, vecs[i].len, vecs[i].mask,
                    vecs[i].poke, vecs[i].exp_done, vecs[i].exp_acc);

        // reset in the middle of a load, after two beats have been delivered
        @(negedge CLK);
        CMD_VALID = 1'b1; CMD_STORE = 1'b0; CMD_BASE = 32'h30; CMD_LEN = 4'd7; CMD_PE_MASK = 4'hF;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        nv = 0;
        repeat (3) begin
            @(negedge CLK);
            if (PE_DIN_VALID != 4'h0) nv++;
        end
        chk("midreset beats_before", 128'(nv), 128'(2));
        #1 RST = 1'b1;
        #1;
        chk("midreset ready", CMD_READY, 1'b1);
        chk("midreset busy", BUSY, 1'b0);
        chk("midreset enb", enb, 1'b0);
        chk("midreset web", web, 4'h0);
        chk("midreset din_valid", PE_DIN_VALID, 4'h0);
        @(negedge CLK);
        RST = 1'b0;
        nbad = 0;
        repeat (12) begin
            @(negedge CLK);
            if (PE_DIN_VALID != 4'h0 || DONE || enb || !CMD_READY) nbad++;
        end
        chk("midreset quiet_after", 128'(nbad), 128'(0));
        run_cmd("post_reset_load", 1'b0, 32'h10, 4'd3, 4'hF, 1'b0, 6, 4);

        for (int r = 0; r < 40; r++) begin
            st   = 1'($urandom_range(0, 1));
            base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            len  = 4'($urandom_range(0, 15));
            mask = 4'($urandom_range(0, 15));
            n    = $countones(mask);
            d    = (mask == 0) ? 1 : st ? n * (int'(len) + 1) + 1 : int'(len) + 2 + LAT;
            acc  = (mask == 0) ? 0 : st ? n * (int'(len) + 1) : int'(len) + 1;
            poke = d >= 3 && $urandom_range(0, 3) == 0;
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_cmd($sformatf("rnd%0d", r), st, base, len, mask, poke, d, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
